sdram_cmd_arbiter: RTL and testbench
====================================

// Module: sdram_cmd_arbiter
// PURPOSE
//  Parametrised N-channel command arbiter in front of SDRAM_16bit, running in the SDRAM clock domain.
//  Replaces the fixed video/cache-write/cache-read if-chain in the top level.
//  Grants one channel at a time and drives sys_CMD/sys_ADDR until the controller acks.
//  Routes the burst's rd/wr data-valid strobes to the owning channel, counting words to detect burst end.
// PARAMETERS
//  NCH      3    number of request channels; channel 0 is urgent (video refill)
//  AW       23   sys_ADDR width (word address)
//  SBURST   16   words in a short read (cmd 2'b10, 32 bytes)
//  LBURST   128  words in a long read/write (cmd 2'b11 / 2'b01, 256 bytes)
// PORTS
//  clk            in   1       SDRAM-domain clock (100 MHz)
//  rst            in   1       asynchronous, active-low reset
//  req            in   NCH     per-channel request; level, held until gnt
//  cmd            in   2*NCH   per-channel command: 01 wr256, 10 rd32, 11 rd256; 00 = no request
//  addr           in   AW*NCH  per-channel word address
//  gnt            out  NCH     one-cycle pulse to the owner when the controller acks
//  rd_valid       out  NCH     sys_rd_data_valid, gated to the owner
//  wr_valid       out  NCH     sys_wr_data_valid, gated to the owner
//  owner          out  $clog2(NCH)  index of the current owner; valid while busy
//  busy           out  1       high from issue through burst end
//  err            out  1       sticky error flag; cleared only by reset
//  sys_CMD        out  2       to controller
//  sys_ADDR       out  AW      to controller
//  sys_cmd_ack    in   2       from controller
//  sys_rd_data_valid, sys_wr_data_valid  in 1  from controller
// BEHAVIOUR
//  Reset: all outputs are 0, sys_CMD=00, state=IDLE, word count=0.
//  A channel is eligible when req[i]=1 and cmd[i]!=00.
//  States:
//   IDLE:  if any channel is eligible, pick the winner, latch its cmd/addr/index, go to ISSUE.
//          sys_CMD/sys_ADDR are registered, so they appear 1 cycle after the req is seen.
//   ISSUE: hold sys_CMD/sys_ADDR.
//          ack_edge = (previous sys_cmd_ack==00) && (sys_cmd_ack!=00).
//          On ack_edge: pulse gnt[owner]; sys_CMD<=00 on the next cycle; go to DATA.
//          If the ack code differs from the latched cmd, set err but proceed with the latched length.
//   DATA:  forward the valid matching the direction (rd for 10/11, wr for 01) to owner; count words.
//          When count reaches the burst length (SBURST for 10, else LBURST), return to IDLE
//          on the cycle after the final valid; the next issue is possible in that same IDLE cycle.
//  Selection: channel 0 always wins if eligible. Channels 1..NCH-1 are picked as set by ARB_ROUND_ROBIN_EN.
//  Boundary cases:
//   - A valid strobe seen in IDLE/ISSUE, or of the wrong direction in DATA: dropped, err set.
//   - req dropped after latch: the command still completes.
//   - All req asserted simultaneously: channel 0 is granted; the others wait, with no starvation of channel 0.
//   - Async reset mid-burst: return to IDLE immediately; the in-flight burst is abandoned.
//  Word counter: $clog2(LBURST)+1 bits; it does not wrap within a burst.
// CONFIGURATION
//  ARB_ROUND_ROBIN_EN defined: channels 1..NCH-1 are served round-robin.
//   The pointer advances to one past the last non-zero owner on each grant.
//  Undefined: fixed priority, lowest index wins (matches the legacy order video > wr > rd).
// STRUCTURE
//  Package sdram_arb_pkg holds:
//   - cmd codes CMD_NOP/CMD_WR256/CMD_RD32/CMD_RD256
//   - state enum {IDLE,ISSUE,DATA}
//   - a burst-length function of the cmd code
//  Sub-module rr_pick: combinational one-hot winner from an eligible mask and pointer, parametrised by NCH.
// TESTING
//  T1: ch2 req cmd=11 addr=0x1234 -> sys_CMD=11 and sys_ADDR=0x1234 the next cycle;
//      ack 11 after 5 cycles -> gnt[2] pulse; 128 rd_valid[2]; busy low afterwards.
//  T2: ch0 (10) and ch1 (01) requested in the same cycle -> ch0 is served first
//      (16 rd_valid[0]), then ch1 (128 wr_valid[1]).
//  T3 (RR_EN): ch1 and ch2 request continuously -> grants alternate 1,2,1,2.
//      Without the macro -> ch1 on every grant.
//  T4: rd_valid pulse while IDLE -> err=1, no rd_valid output; err persists until rst.
//  T5: rst low after 40 of 128 words -> all outputs 0 within the same edge;
//      after rst high, a fresh ch0 req issues normally with count restarting at 0.
//  T6: ack code 10 returned for cmd 11 -> err=1; still 128 words counted.

Source files
------------

// File: rtl/sdram_arb_pkg.sv
// rtl/sdram_arb_pkg.sv - command codes, FSM states and burst-length helper for the SDRAM command arbiter
package sdram_arb_pkg;

    localparam logic [1:0] CMD_NOP   = 2'b00;
    localparam logic [1:0] CMD_WR256 = 2'b01;
    localparam logic [1:0] CMD_RD32  = 2'b10;
    localparam logic [1:0] CMD_RD256 = 2'b11;

    typedef enum logic [1:0] {IDLE, ISSUE, DATA} state_t;

    function automatic int burst_len(input logic [1:0] code, input int sburst, input int lburst);
        return (code == CMD_RD32) ? sburst : lburst;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational one-hot pick of the first eligible channel at or after a rotating pointer
module rr_pick #(
    parameter int NCH = 3,
    parameter int IW  = 2
) (
    input  logic [NCH-1:0] mask,
    input  logic [IW-1:0]  ptr,
    output logic [NCH-1:0] grant
);
    logic [NCH-1:0] rot;
    logic [NCH-1:0] first;

    // Rotate so the pointer sits at bit 0, isolate the lowest set bit, rotate back.
    always_comb begin
        rot   = NCH'({mask, mask} >> ptr);
        first = rot & (~rot + 1'b1);
        grant = NCH'(({first, first} << ptr) >> NCH);
    end

endmodule

// File: rtl/sdram_cmd_arbiter.sv
// rtl/sdram_cmd_arbiter.sv - N-channel SDRAM command arbiter with burst data-valid routing
// Define ARB_ROUND_ROBIN_EN to serve channels 1..NCH-1 round-robin instead of fixed priority.
module sdram_cmd_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int  NCH    = 3,
    parameter int  AW     = 23,
    parameter int  SBURST = 16,
    parameter int  LBURST = 128,
    localparam int IW     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    req,
    input  logic [2*NCH-1:0]  cmd,
    input  logic [AW*NCH-1:0] addr,
    output logic [NCH-1:0]    gnt,
    output logic [NCH-1:0]    rd_valid,
    output logic [NCH-1:0]    wr_valid,
    output logic [IW-1:0]     owner,
    output logic              busy,
    output logic              err,
    output logic [1:0]        sys_CMD,
    output logic [AW-1:0]     sys_ADDR,
    input  logic [1:0]        sys_cmd_ack,
    input  logic              sys_rd_data_valid,
    input  logic              sys_wr_data_valid
);
    localparam int CW = $clog2(LBURST) + 1;

    state_t         state;
    logic [1:0]     cur_cmd;
    logic [1:0]     prev_ack;
    logic [IW-1:0]  ptr;
    logic [CW-1:0]  count;
    logic [CW-1:0]  count_nxt;
    logic [CW-1:0]  burst_words;
    logic [NCH-1:0] elig;
    logic [NCH-1:0] rr_win;
    logic [NCH-1:0] win;
    logic [NCH-1:0] owner_oh;
    logic [IW-1:0]  win_idx;
    logic [1:0]     win_cmd;
    logic [AW-1:0]  win_addr;
    logic           ack_edge;
    logic           is_rd;
    logic           dir_valid;
    logic           wrong_valid;
    logic           any_valid;

    always_comb begin
        elig = '0;
        for (int i = 0; i < NCH; i++) begin
            elig[i] = req[i] && (cmd[2*i +: 2] != CMD_NOP);
        end
    end

    rr_pick #(.NCH(NCH), .IW(IW)) u_pick (
        .mask  (elig),
        .ptr   (ptr),
        .grant (rr_win)
    );

    // Channel 0 (video refill) pre-empts whatever the pointer would choose.
    always_comb begin
        win      = elig[0] ? NCH'(1) : rr_win;
        win_idx  = '0;
        win_cmd  = CMD_NOP;
        win_addr = '0;
        for (int i = 0; i < NCH; i++) begin
            if (win[i]) begin
                win_idx  = IW'(i);
                win_cmd  = cmd[2*i +: 2];
                win_addr = addr[AW*i +: AW];
            end
        end
    end

    assign ack_edge    = (prev_ack == CMD_NOP) && (sys_cmd_ack != CMD_NOP);
    assign is_rd       = (cur_cmd == CMD_RD32) || (cur_cmd == CMD_RD256);
    assign dir_valid   = is_rd ? sys_rd_data_valid : sys_wr_data_valid;
    assign wrong_valid = is_rd ? sys_wr_data_valid : sys_rd_data_valid;
    assign any_valid   = sys_rd_data_valid || sys_wr_data_valid;
    assign owner_oh    = NCH'(1) << owner;
    assign count_nxt   = count + 1'b1;
    assign burst_words = CW'(burst_len(cur_cmd, SBURST, LBURST));
    assign rd_valid    = (state == DATA && is_rd && sys_rd_data_valid) ? owner_oh : '0;
    assign wr_valid    = (state == DATA && !is_rd && sys_wr_data_valid) ? owner_oh : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cur_cmd  <= CMD_NOP;
            prev_ack <= CMD_NOP;
            ptr      <= IW'(1);
            count    <= '0;
            gnt      <= '0;
            owner    <= '0;
            busy     <= 1'b0;
            err      <= 1'b0;
            sys_CMD  <= CMD_NOP;
            sys_ADDR <= '0;
        end else begin
            prev_ack <= sys_cmd_ack;
            gnt      <= '0;
            case (state)
                IDLE: begin
                    if (any_valid) err <= 1'b1;
                    if (|elig) begin
                        cur_cmd  <= win_cmd;
                        owner    <= win_idx;
                        sys_CMD  <= win_cmd;
                        sys_ADDR <= win_addr;
                        busy     <= 1'b1;
                        count    <= '0;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (any_valid) err <= 1'b1;
                    if (ack_edge) begin
                        gnt     <= owner_oh;
                        sys_CMD <= CMD_NOP;
                        state   <= DATA;
                        // A mismatched ack is flagged, but the burst length stays the latched one.
                        if (sys_cmd_ack != cur_cmd) err <= 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
                        if (owner != '0) ptr <= (owner == IW'(NCH-1)) ? IW'(1) : owner + 1'b1;
`endif
                    end
                end
                DATA: begin
                    if (wrong_valid) err <= 1'b1;
                    if (dir_valid) begin
                        count <= count_nxt;
                        if (count_nxt == burst_words) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sdram_cmd_arbiter.sv
// tb/tb_sdram_cmd_arbiter.sv - randomized self-checking bench for sdram_cmd_arbiter against a behavioural model
module tb_sdram_cmd_arbiter;
    localparam int NCH = 3, AW = 23, SBURST = 16, LBURST = 128;

    logic clk = 1'b0;
    logic rst;
    logic [NCH-1:0] req;
    logic [2*NCH-1:0] cmd;
    logic [AW*NCH-1:0] addr;
    logic [NCH-1:0] gnt, rd_valid, wr_valid;
    logic [1:0] owner;
    logic busy, err;
    logic [1:0] sys_CMD;
    logic [AW-1:0] sys_ADDR;
    logic [1:0] sys_cmd_ack;
    logic sys_rd_data_valid, sys_wr_data_valid;

    int checks = 0;
    int failures = 0;

    int mptr;
    bit keep_req;
    int obs_wait, obs_timeout, obs_busy_after;
    logic [1:0] obs_cmd, obs_hold, obs_cmd_after, obs_owner;
    logic [AW-1:0] obs_addr;
    logic [NCH-1:0] obs_gnt, obs_gnt2;
    int obs_rd[NCH];
    int obs_wr[NCH];

    always #5 clk = ~clk;

    sdram_cmd_arbiter #(.NCH(NCH), .AW(AW), .SBURST(SBURST), .LBURST(LBURST)) dut (
        .clk(clk), .rst(rst), .req(req), .cmd(cmd), .addr(addr),
        .gnt(gnt), .rd_valid(rd_valid), .wr_valid(wr_valid), .owner(owner),
        .busy(busy), .err(err), .sys_CMD(sys_CMD), .sys_ADDR(sys_ADDR),
        .sys_cmd_ack(sys_cmd_ack), .sys_rd_data_valid(sys_rd_data_valid),
        .sys_wr_data_valid(sys_wr_data_valid)
    );

    function automatic int exp_len(input logic [1:0] c);
        return (c == 2'b10) ? SBURST : LBURST;
    endfunction

    // Winner from the arbitration rules: ch0 first, then pointer order or lowest index.
    function automatic int model_pick(input logic [NCH-1:0] e, input int p);
        if (e[0]) return 0;
`ifdef ARB_ROUND_ROBIN_EN
        for (int k = 0; k < NCH-1; k++) begin
            int c;
            c = 1 + (p - 1 + k) % (NCH - 1);
            if (e[c]) return c;
        end
`else
        for (int c = 1; c < NCH; c++) if (e[c]) return c;
`endif
        return 0;
    endfunction

    task automatic model_grant(input int c);
        if (c != 0) mptr = (c == NCH-1) ? 1 : c + 1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_chan(input int c, input logic [1:0] cm, input logic [AW-1:0] a);
        req[c] = 1'b1;
        cmd[2*c +: 2] = cm;
        addr[AW*c +: AW] = a;
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        req = '0; cmd = '0; addr = '0;
        sys_cmd_ack = 2'b00; sys_rd_data_valid = 1'b0; sys_wr_data_valid = 1'b0;
        keep_req = 1'b0;
        mptr = 1;
        repeat (2) tick();
        rst = 1'b1;
        tick();
    endtask

    // Acts as the SDRAM controller for one command and records what the arbiter did.
    task automatic serve(input logic [1:0] ack_code, input int ack_delay);
        int n, len;
        n = 0;
        obs_timeout = 0;
        for (int c = 0; c < NCH; c++) begin obs_rd[c] = 0; obs_wr[c] = 0; end
        while (sys_CMD == 2'b00 && n < 64) begin tick(); n++; end
        obs_wait = n;
        if (sys_CMD == 2'b00) begin obs_timeout = 1; return; end
        obs_cmd = sys_CMD; obs_addr = sys_ADDR; obs_owner = owner;
        repeat (ack_delay) tick();
        obs_hold = sys_CMD;
        sys_cmd_ack = (ack_code == 2'b00) ? obs_cmd : ack_code;
        tick();
        obs_gnt = gnt; obs_cmd_after = sys_CMD;
        if (!keep_req) req = req & ~gnt;
        sys_cmd_ack = 2'b00;
        tick();
        obs_gnt2 = gnt;
        len = exp_len(obs_cmd);
        for (int w = 0; w < len; w++) begin
            if ($urandom_range(3) == 0) tick();
            if (obs_cmd == 2'b01) sys_wr_data_valid = 1'b1; else sys_rd_data_valid = 1'b1;
            #1;
            for (int c = 0; c < NCH; c++) begin
                obs_rd[c] += int'(rd_valid[c]);
                obs_wr[c] += int'(wr_valid[c]);
            end
            tick();
            sys_rd_data_valid = 1'b0; sys_wr_data_valid = 1'b0;
        end
        obs_busy_after = int'(busy);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        req = 3'b111; cmd = 6'b111111; addr = '1;
        sys_cmd_ack = 2'b11; sys_rd_data_valid = 1'b0; sys_wr_data_valid = 1'b0;
        repeat (2) tick();
        checks++; if ({sys_CMD, sys_ADDR} !== '0) begin failures++; $display("FAIL reset_sys: got %h/%h want 0/0", sys_CMD, sys_ADDR); end
        checks++; if ({gnt, rd_valid, wr_valid} !== '0) begin failures++; $display("FAIL reset_strobes: got %b want 0", {gnt, rd_valid, wr_valid}); end
        checks++; if ({owner, busy, err} !== '0) begin failures++; $display("FAIL reset_status: got %b want 0", {owner, busy, err}); end
        apply_reset();
    endtask

    task automatic test_single();
        set_chan(2, 2'b11, 23'h1234);
        serve(2'b00, 5);
        checks++; if (obs_timeout != 0) begin failures++; $display("FAIL t1_issue: got timeout want issue"); end
        checks++; if (obs_wait != 1) begin failures++; $display("FAIL t1_latency: got %0d want 1", obs_wait); end
        checks++; if (obs_cmd !== 2'b11 || obs_addr !== 23'h1234) begin failures++; $display("FAIL t1_cmd_addr: got %b/%h want 11/1234", obs_cmd, obs_addr); end
        checks++; if (obs_hold !== 2'b11) begin failures++; $display("FAIL t1_hold: got %b want 11", obs_hold); end
        checks++; if (obs_gnt !== 3'b100 || obs_gnt2 !== 3'b000) begin failures++; $display("FAIL t1_gnt_pulse: got %b,%b want 100,000", obs_gnt, obs_gnt2); end
        checks++; if (obs_cmd_after !== 2'b00) begin failures++; $display("FAIL t1_cmd_clear: got %b want 00", obs_cmd_after); end
        checks++; if (obs_rd[2] != LBURST || obs_rd[0] + obs_rd[1] + obs_wr[0] + obs_wr[1] + obs_wr[2] != 0) begin failures++; $display("FAIL t1_words: got rd2=%0d other=%0d want %0d,0", obs_rd[2], obs_rd[0] + obs_rd[1] + obs_wr[0] + obs_wr[1] + obs_wr[2], LBURST); end
        checks++; if (obs_busy_after != 0 || err !== 1'b0) begin failures++; $display("FAIL t1_busy_err: got busy=%0d err=%b want 0,0", obs_busy_after, err); end
    endtask

    task automatic test_back_to_back();
        set_chan(0, 2'b10, 23'h000100);
        set_chan(1, 2'b01, 23'h7fff00);
        serve(2'b00, 2);
        checks++; if (obs_owner !== 2'd0 || obs_addr !== 23'h000100) begin failures++; $display("FAIL t2_first_owner: got %0d/%h want 0/000100", obs_owner, obs_addr); end
        checks++; if (obs_rd[0] != SBURST || obs_busy_after != 0) begin failures++; $display("FAIL t2_first_words: got %0d busy=%0d want %0d,0", obs_rd[0], obs_busy_after, SBURST); end
        serve(2'b00, 3);
        checks++; if (obs_wait != 1) begin failures++; $display("FAIL t2_reissue_latency: got %0d want 1", obs_wait); end
        checks++; if (obs_owner !== 2'd1 || obs_cmd !== 2'b01) begin failures++; $display("FAIL t2_second_owner: got %0d/%b want 1/01", obs_owner, obs_cmd); end
        checks++; if (obs_wr[1] != LBURST || obs_rd[0] + obs_rd[1] + obs_rd[2] != 0) begin failures++; $display("FAIL t2_second_words: got wr1=%0d rd=%0d want %0d,0", obs_wr[1], obs_rd[0] + obs_rd[1] + obs_rd[2], LBURST); end
        req = '0; cmd = '0;
    endtask

    task automatic test_random();
        logic [NCH-1:0] pend;
        logic [1:0] ecmd[NCH];
        logic [AW-1:0] eaddr[NCH];
        int e, tot, own_cnt;
        for (int it = 0; it < 5; it++) begin
            pend = '0;
            for (int c = 0; c < NCH; c++) begin
                ecmd[c] = 2'($urandom_range(3, 1));
                eaddr[c] = AW'($urandom);
                if ($urandom_range(1) == 1) begin
                    set_chan(c, ecmd[c], eaddr[c]);
                    pend[c] = 1'b1;
                end else if ($urandom_range(1) == 1) begin
                    set_chan(c, 2'b00, eaddr[c]);
                end
            end
            while (pend != '0) begin
                e = model_pick(pend, mptr);
                serve(2'b00, $urandom_range(4, 1));
                checks++; if (obs_timeout != 0 || obs_owner !== 2'(e)) begin failures++; $display("FAIL rand_owner: got %0d (timeout=%0d) want %0d", obs_owner, obs_timeout, e); end
                checks++; if (obs_cmd !== ecmd[e] || obs_addr !== eaddr[e]) begin failures++; $display("FAIL rand_cmd_addr: got %b/%h want %b/%h", obs_cmd, obs_addr, ecmd[e], eaddr[e]); end
                tot = 0;
                for (int c = 0; c < NCH; c++) tot += obs_rd[c] + obs_wr[c];
                own_cnt = (ecmd[e] == 2'b01) ? obs_wr[e] : obs_rd[e];
                checks++; if (own_cnt != exp_len(ecmd[e]) || tot != exp_len(ecmd[e])) begin failures++; $display("FAIL rand_words: got own=%0d total=%0d want %0d", own_cnt, tot, exp_len(ecmd[e])); end
                model_grant(e);
                pend[e] = 1'b0;
            end
            repeat (3) tick();
            checks++; if (busy !== 1'b0 || sys_CMD !== 2'b00) begin failures++; $display("FAIL rand_ineligible_idle: got busy=%b cmd=%b want 0,00", busy, sys_CMD); end
            req = '0; cmd = '0;
        end
    endtask

    task automatic test_round_robin();
        int e;
        apply_reset();
        keep_req = 1'b1;
        set_chan(1, 2'b10, 23'h000011);
        set_chan(2, 2'b10, 23'h000022);
        for (int k = 0; k < 4; k++) begin
            e = model_pick(3'b110, mptr);
            serve(2'b00, 1);
            checks++; if (obs_owner !== 2'(e) || obs_gnt !== 3'(1 << e)) begin failures++; $display("FAIL rr_grant_%0d: got owner=%0d gnt=%b want %0d", k, obs_owner, obs_gnt, e); end
            model_grant(e);
        end
        keep_req = 1'b0;
        req = '0; cmd = '0;
    endtask

    task automatic test_stray_valid();
        apply_reset();
        checks++; if (err !== 1'b0) begin failures++; $display("FAIL t4_err_clear: got %b want 0", err); end
        sys_rd_data_valid = 1'b1;
        #1;
        checks++; if (rd_valid !== 3'b000) begin failures++; $display("FAIL t4_no_forward: got %b want 000", rd_valid); end
        tick();
        sys_rd_data_valid = 1'b0;
        checks++; if (err !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL t4_err_set: got err=%b busy=%b want 1,0", err, busy); end
        repeat (5) tick();
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL t4_err_sticky: got %b want 1", err); end
    endtask

    task automatic test_ack_mismatch();
        apply_reset();
        set_chan(1, 2'b11, AW'($urandom));
        serve(2'b10, 2);
        checks++; if (err !== 1'b1) begin failures++; $display("FAIL t6_err: got %b want 1", err); end
        checks++; if (obs_rd[1] != LBURST || obs_busy_after != 0) begin failures++; $display("FAIL t6_length: got %0d busy=%0d want %0d,0", obs_rd[1], obs_busy_after, LBURST); end
    endtask

    task automatic test_reset_mid_burst();
        int n;
        logic [AW-1:0] a0;
        apply_reset();
        set_chan(2, 2'b11, 23'h0abcde);
        n = 0;
        while (sys_CMD == 2'b00 && n < 64) begin tick(); n++; end
        checks++; if (sys_CMD !== 2'b11) begin failures++; $display("FAIL t5_issue: got %b want 11", sys_CMD); end
        sys_cmd_ack = 2'b11;
        tick();
        sys_cmd_ack = 2'b00;
        req = '0;
        tick();
        for (int w = 0; w < 40; w++) begin
            sys_rd_data_valid = 1'b1;
            tick();
        end
        #2;
        rst = 1'b0;
        #1;
        checks++; if ({gnt, rd_valid, wr_valid, owner, busy, err, sys_CMD, sys_ADDR} !== '0) begin failures++; $display("FAIL t5_async_clear: got %h want 0", {gnt, rd_valid, wr_valid, owner, busy, err, sys_CMD, sys_ADDR}); end
        sys_rd_data_valid = 1'b0;
        mptr = 1;
        tick();
        rst = 1'b1;
        tick();
        a0 = AW'($urandom);
        set_chan(0, 2'b10, a0);
        serve(2'b00, 3);
        checks++; if (obs_owner !== 2'd0 || obs_addr !== a0) begin failures++; $display("FAIL t5_fresh_owner: got %0d/%h want 0/%h", obs_owner, obs_addr, a0); end
        checks++; if (obs_rd[0] != SBURST || obs_busy_after != 0 || err !== 1'b0) begin failures++; $display("FAIL t5_fresh_words: got %0d busy=%0d err=%b want %0d,0,0", obs_rd[0], obs_busy_after, err, SBURST); end
    endtask

    initial begin
        #400000;
        failures++;
        $display("FAIL watchdog: got no completion want finish before time limit");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_random();
        test_round_robin();
        test_ack_mismatch();
        test_stray_valid();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
